// File: rtl/s382_sig_compactor.sv
// Response compactor for the s382 core outputs: folds a programmed number of samples into a
// 16-bit MISR signature and counts output-vector toggles, reported via start/busy/done.
module s382_sig_compactor #(
    parameter int unsigned   DIN_W = 6,
    parameter int unsigned   SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY = 16'h1009,
    parameter logic [SIG_W-1:0] SEED = 16'hFFFF,
    parameter int unsigned   LEN_W = 8
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [DIN_W-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic [LEN_W-1:0] toggles
);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e           state_q;
    logic [LEN_W-1:0] remaining_q;
    logic [DIN_W-1:0] prev_q;

    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                   input logic [DIN_W-1:0] d);
        logic [SIG_W-1:0] nxt;
        nxt = {sig[SIG_W-2:0], 1'b0};
        if (sig[SIG_W-1]) begin
            nxt = nxt ^ POLY;
        end
        return nxt ^ SIG_W'(d);
    endfunction

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q     <= StIdle;
            busy        <= 1'b0;
            done        <= 1'b0;
            signature   <= SEED;
            toggles     <= '0;
            remaining_q <= '0;
            prev_q      <= '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    signature   <= misr_step(signature, din);
                    toggles     <= toggles + LEN_W'(din != prev_q);
                    prev_q      <= din;
                    remaining_q <= remaining_q - 1'b1;
                    if (remaining_q == LEN_W'(1)) begin
                        state_q <= StFin;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and FIN accept a start identically, allowing back-to-back windows.
                    done    <= 1'b0;
                    state_q <= StIdle;
                    if (start) begin
                        signature <= SEED;
                        toggles   <= '0;
                        if (len != '0) begin
                            state_q     <= StRun;
                            busy        <= 1'b1;
                            remaining_q <= len;
                            prev_q      <= din;
                        end else begin
                            state_q <= StFin;
                            done    <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
